// File: rtl/uart_pkg.sv
// Shared UART state encodings, idle line level and timer width helper.
package uart_pkg;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Bits needed to hold CLKS_PER_BIT-1.
  function automatic int cnt_width(input int clks);
    return (clks > 2) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load a start value, then o_tc is high once it reaches zero.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250,
  parameter int CW           = cnt_width(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART (TX serialiser + RX deserialiser) with fixed integer baud divide.
// Define UART_LOOPBACK_EN to feed the RX path from tx_out instead of rx_in.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic [1:0]           o_tx_state,
  output logic [1:0]           o_rx_state
);

  localparam int            CW        = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  // ---------------- TX ----------------
  tx_state_t            r_tx_state, w_tx_state_nxt;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
  logic [3:0]           r_tx_bit, w_tx_bit_nxt;
  logic                 r_tx_stop, w_tx_stop_nxt;
  logic                 r_tx_out, w_tx_out_nxt;
  logic                 w_tx_load, w_tx_tc;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tx_load),
    .i_load_val (BIT_LOAD),
    .o_tc       (w_tx_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_out   <= IDLE_LEVEL;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_stop  <= w_tx_stop_nxt;
      r_tx_out   <= w_tx_out_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_stop_nxt  = r_tx_stop;
    w_tx_load      = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (tx_start) begin
          w_tx_state_nxt = TX_START;
          w_tx_shift_nxt = tx_data;
          w_tx_load      = 1'b1;
        end
      end
      TX_START: begin
        if (w_tx_tc) begin
          w_tx_state_nxt = TX_DATA;
          w_tx_bit_nxt   = '0;
          w_tx_load      = 1'b1;
        end
      end
      TX_DATA: begin
        if (w_tx_tc) begin
          w_tx_load      = 1'b1;
          w_tx_shift_nxt = r_tx_shift >> 1;
          if (r_tx_bit == LAST_BIT) begin
            w_tx_state_nxt = TX_STOP;
            w_tx_stop_nxt  = 1'b0;
          end else begin
            w_tx_bit_nxt = r_tx_bit + 4'd1;
          end
        end
      end
      TX_STOP: begin
        if (w_tx_tc) begin
          if (r_tx_stop == LAST_STOP) begin
            w_tx_state_nxt = TX_IDLE;
          end else begin
            w_tx_stop_nxt = 1'b1;
            w_tx_load     = 1'b1;
          end
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
    // Line level is registered from the next state so the pin never glitches.
    case (w_tx_state_nxt)
      TX_START: w_tx_out_nxt = ~IDLE_LEVEL;
      TX_DATA:  w_tx_out_nxt = w_tx_shift_nxt[0];
      default:  w_tx_out_nxt = IDLE_LEVEL;
    endcase
  end

  assign tx_out     = r_tx_out;
  assign tx_ready   = (r_tx_state == TX_IDLE);
  assign o_tx_state = r_tx_state;

  // ---------------- RX ----------------
  logic w_rx_line;
`ifdef UART_LOOPBACK_EN
  assign w_rx_line = r_tx_out;
`else
  assign w_rx_line = rx_in;
`endif

  rx_state_t            r_rx_state, w_rx_state_nxt;
  logic                 r_rx_meta, r_rx_sync, r_rx_prev;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [DATA_BITS-1:0] r_rx_data, w_rx_data_nxt;
  logic [3:0]           r_rx_bit, w_rx_bit_nxt;
  logic                 r_rx_stop, w_rx_stop_nxt;
  logic                 r_rx_err, w_rx_err_nxt;
  logic                 r_rx_valid, w_rx_valid_nxt;
  logic                 w_rx_load, w_rx_tc;
  logic [CW-1:0]        w_rx_load_val;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_rx_load),
    .i_load_val (w_rx_load_val),
    .o_tc       (w_rx_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta  <= IDLE_LEVEL;
      r_rx_sync  <= IDLE_LEVEL;
      r_rx_prev  <= IDLE_LEVEL;
      r_rx_state <= RX_IDLE;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_bit   <= '0;
      r_rx_stop  <= 1'b0;
      r_rx_err   <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_meta  <= w_rx_line;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_stop  <= w_rx_stop_nxt;
      r_rx_err   <= w_rx_err_nxt;
      r_rx_valid <= w_rx_valid_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_data_nxt  = r_rx_data;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_stop_nxt  = r_rx_stop;
    w_rx_err_nxt   = r_rx_err;
    w_rx_valid_nxt = 1'b0;
    w_rx_load      = 1'b0;
    w_rx_load_val  = BIT_LOAD;
    case (r_rx_state)
      RX_IDLE: begin
        // Edge, not level: a held-low break cannot retrigger.
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_rx_load      = 1'b1;
          w_rx_load_val  = HALF_LOAD;
        end
      end
      RX_START: begin
        if (w_rx_tc) begin
          if (!r_rx_sync) begin
            w_rx_state_nxt = RX_DATA;
            w_rx_bit_nxt   = '0;
            w_rx_load      = 1'b1;
          end else begin
            w_rx_state_nxt = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (w_rx_tc) begin
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
          w_rx_load      = 1'b1;
          if (r_rx_bit == LAST_BIT) begin
            w_rx_state_nxt = RX_STOP;
            w_rx_stop_nxt  = 1'b0;
            w_rx_err_nxt   = 1'b0;
          end else begin
            w_rx_bit_nxt = r_rx_bit + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (w_rx_tc) begin
          if (r_rx_stop == LAST_STOP) begin
            w_rx_state_nxt = RX_IDLE;
            if (r_rx_sync && !r_rx_err) begin
              w_rx_valid_nxt = 1'b1;
              w_rx_data_nxt  = r_rx_shift;
            end
          end else begin
            w_rx_err_nxt  = r_rx_err | ~r_rx_sync;
            w_rx_stop_nxt = 1'b1;
            w_rx_load     = 1'b1;
          end
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  assign rx_valid   = r_rx_valid;
  assign rx_data    = r_rx_data;
  assign o_rx_state = r_rx_state;

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: frame-level TX model, RX byte scoreboard, loopback.
module tb_uart_transceiver;
  import uart_pkg::*;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;
`ifdef UART_LOOPBACK_EN
  localparam bit LOOP_BUILT = 1'b1;
`else
  localparam bit LOOP_BUILT = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_out, rx_valid;
  logic [7:0] rx_data;
  logic       rx_in;
  logic       rx_drive = 1'b1;
  logic       loop_mode = 1'b0;
  logic [1:0] dbg_tx, dbg_rx;

  always #5 clk = ~clk;

  assign rx_in = loop_mode ? tx_out : rx_drive;

  uart_transceiver #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_out     (tx_out),
    .rx_in      (rx_in),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .o_tx_state (dbg_tx),
    .o_rx_state (dbg_rx)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int valid_cyc = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      logic [7:0] e;
      rx_cnt++;
      valid_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rx_unexpected: rx_valid with rx_data=%h, required no rx_valid", rx_data);
      end else begin
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          n_errors++;
          $display("FAIL rx_data: got %h, required %h", rx_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_and_check_tx(input logic [7:0] d, input bit poke, output int ready_cyc);
    logic [9:0] frame;
    logic       bad, seen_out, seen_rdy;
    int         cnt, s;
    frame = {1'b1, d, 1'b0};
    ready_cyc = 0;
    cnt = 0;
    while (tx_ready !== 1'b1 && cnt < 2 * FRAME) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL tx_wait_ready: tx_ready=%b, required 1 within %0d cycles", tx_ready, 2 * FRAME);
      return;
    end
    if (LOOP_BUILT || loop_mode) exp_q.push_back(d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom_range(0, 255));
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL tx_ready_after_start: got %b, required 0", tx_ready);
    end
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      seen_out = tx_out;
      seen_rdy = tx_ready;
      for (int c = 0; c < CPB; c++) begin
        if (tx_out !== frame[b] || tx_ready !== 1'b0) begin
          bad = 1'b1;
          seen_out = tx_out;
          seen_rdy = tx_ready;
        end
        s = b * CPB + c;
        if (poke && s == 5 * CPB) begin
          tx_start = 1'b1;
          tx_data  = ~d;
        end else if (poke && s == 5 * CPB + 1) begin
          tx_start = 1'b0;
        end
        @(negedge clk);
      end
      n_checks++;
      if (bad) begin
        n_errors++;
        $display("FAIL tx_bit%0d of %h: tx_out=%b tx_ready=%b, required tx_out=%b tx_ready=0",
                 b, d, seen_out, seen_rdy, frame[b]);
      end
    end
    n_checks++;
    if (tx_ready !== 1'b1 || tx_out !== 1'b1) begin
      n_errors++;
      $display("FAIL tx_end_of_frame %h: tx_ready=%b tx_out=%b, required 1 1", d, tx_ready, tx_out);
    end
    ready_cyc = cyc;
  endtask

  task automatic drive_rx_frame(input logic [7:0] d, input logic stop_lvl);
    logic [9:0] f;
    f = {stop_lvl, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_drive = f[b];
      repeat (CPB) @(negedge clk);
    end
    rx_drive = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_out !== 1'b1) begin n_errors++; $display("FAIL reset_tx_out: got %b, required 1", tx_out); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_errors++; $display("FAIL reset_tx_ready: got %b, required 1", tx_ready); end
    n_checks++;
    if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rx_valid: got %b, required 0", rx_valid); end
    n_checks++;
    if (rx_data !== 8'h00) begin n_errors++; $display("FAIL reset_rx_data: got %h, required 00", rx_data); end
    n_checks++;
    if (dbg_tx !== TX_IDLE || dbg_rx !== RX_IDLE) begin
      n_errors++;
      $display("FAIL reset_states: tx=%0d rx=%0d, required idle", dbg_tx, dbg_rx);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx_pattern();
    int rc;
    send_and_check_tx(8'hA5, 1'b0, rc);
    send_and_check_tx(8'($urandom_range(0, 255)), 1'b1, rc);
    send_and_check_tx(8'($urandom_range(0, 255)), 1'b0, rc);
    send_and_check_tx(8'($urandom_range(0, 255)), 1'b1, rc);
  endtask

  task automatic test_loopback_ff();
    int base, rc;
    loop_mode = 1'b1;
    base = rx_cnt;
    send_and_check_tx(8'hFF, 1'b0, rc);
    n_checks++;
    if (rx_cnt - base != 1) begin
      n_errors++;
      $display("FAIL loop_ff_count: got %0d rx_valid, required 1", rx_cnt - base);
    end
    n_checks++;
    if (rx_data !== 8'hFF) begin n_errors++; $display("FAIL loop_ff_data: got %h, required ff", rx_data); end
    n_checks++;
    if (!(valid_cyc < rc)) begin
      n_errors++;
      $display("FAIL loop_ff_order: rx_valid cycle %0d, required before tx_ready cycle %0d", valid_cyc, rc);
    end
    last_good = 8'hFF;
    loop_mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base, prev_acc, cnt;
    logic [7:0] b;
    loop_mode = 1'b1;
    base = rx_cnt;
    prev_acc = 0;
    tx_start = 1'b1;
    for (int i = 0; i < 101; i++) begin
      b = (i == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      cnt = 0;
      while (tx_ready !== 1'b1 && cnt < 2 * FRAME) begin
        @(negedge clk);
        cnt++;
      end
      n_checks++;
      if (tx_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_ready_timeout: frame %0d tx_ready=%b, required 1", i, tx_ready);
        break;
      end
      tx_data = b;
      exp_q.push_back(b);
      last_good = b;
      if (i > 0) begin
        n_checks++;
        if (cyc - prev_acc != FRAME + 1) begin
          n_errors++;
          $display("FAIL b2b_gap: frame %0d started %0d cycles after previous, required %0d",
                   i, cyc - prev_acc, FRAME + 1);
        end
      end
      prev_acc = cyc;
      @(negedge clk);
    end
    tx_start = 1'b0;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 2 * FRAME) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_drain: %0d bytes never received, required 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (rx_cnt - base != 101) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d rx_valid, required 101", rx_cnt - base);
    end
    repeat (2 * CPB) @(negedge clk);
    loop_mode = 1'b0;
  endtask

  task automatic test_glitch();
    int base;
    base = rx_cnt;
    rx_drive = 1'b0;
    repeat ((CPB * 300 + 1249) / 1250) @(negedge clk);
    rx_drive = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_checks++;
    if (rx_cnt != base) begin n_errors++; $display("FAIL glitch_valid: got %0d rx_valid, required 0", rx_cnt - base); end
    n_checks++;
    if (dbg_rx !== RX_IDLE) begin n_errors++; $display("FAIL glitch_state: rx state %0d, required idle", dbg_rx); end
    exp_q.push_back(8'h3C);
    drive_rx_frame(8'h3C, 1'b1);
    last_good = 8'h3C;
    n_checks++;
    if (rx_cnt - base != 1) begin n_errors++; $display("FAIL glitch_next_count: got %0d, required 1", rx_cnt - base); end
    n_checks++;
    if (rx_data !== 8'h3C) begin n_errors++; $display("FAIL glitch_next_data: got %h, required 3c", rx_data); end
  endtask

  task automatic test_framing();
    int base;
    base = rx_cnt;
    drive_rx_frame(8'h55, 1'b0);
    n_checks++;
    if (rx_cnt != base) begin n_errors++; $display("FAIL framing_valid: got %0d rx_valid, required 0", rx_cnt - base); end
    n_checks++;
    if (rx_data !== last_good) begin n_errors++; $display("FAIL framing_data: got %h, required %h", rx_data, last_good); end
  endtask

  task automatic test_rx_random_concurrent();
    int base, n_ok;
    base = rx_cnt;
    n_ok = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [7:0] d;
          logic ok;
          d  = 8'($urandom_range(0, 255));
          ok = ($urandom_range(0, 3) != 0);
          if (ok) begin
            exp_q.push_back(d);
            last_good = d;
            n_ok++;
          end
          drive_rx_frame(d, ok);
        end
      end
      begin
        int rc;
        send_and_check_tx(8'($urandom_range(0, 255)), 1'b0, rc);
        send_and_check_tx(8'($urandom_range(0, 255)), 1'b1, rc);
      end
    join
    n_checks++;
    if (rx_cnt - base != n_ok) begin
      n_errors++;
      $display("FAIL rx_random_count: got %0d rx_valid, required %0d", rx_cnt - base, n_ok);
    end
    n_checks++;
    if (rx_data !== last_good) begin n_errors++; $display("FAIL rx_random_hold: got %h, required %h", rx_data, last_good); end
  endtask

  task automatic test_reset_mid_tx();
    int rc;
    tx_data  = 8'($urandom_range(0, 255));
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (4 * CPB + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_tx: tx_out=%b tx_ready=%b rx_valid=%b, required 1 1 0", tx_out, tx_ready, rx_valid);
    end
    n_checks++;
    if (dbg_tx !== TX_IDLE) begin n_errors++; $display("FAIL reset_mid_tx_state: got %0d, required idle", dbg_tx); end
    reset = 1'b0;
    @(negedge clk);
    send_and_check_tx(8'($urandom_range(0, 255)), 1'b0, rc);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_tx_pattern();
    test_loopback_ff();
    test_back_to_back();
`ifndef UART_LOOPBACK_EN
    test_glitch();
    test_framing();
    test_rx_random_concurrent();
`endif
    test_reset_mid_tx();
    repeat (2 * CPB) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL final_queue: %0d expected bytes outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
